// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// Bit timing constants (clock frequency, baud rate) belong to the tick generator.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_STOP_BITS = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or above ptr,
// wrapping around. The pointer register is owned by the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SUM_W = IDX_W + 1;

    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // Candidate gi is the requester gi positions after ptr, reduced modulo NUM_REQ.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [SUM_W-1:0] sum;
        assign sum           = {1'b0, ptr} + SUM_W'(gi);
        assign cand_idx[gi]  = (sum >= SUM_W'(NUM_REQ)) ? IDX_W'(sum - SUM_W'(NUM_REQ))
                                                        : sum[IDX_W-1:0];
        assign hit[gi]       = req[cand_idx[gi]];
    end

    // Walk from the farthest candidate down so the nearest one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (en && hit[i]) begin
                grant              = '0;
                grant[cand_idx[i]] = 1'b1;
                idx                = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 transmit line between NUM_REQ byte sources,
// with bit timing taken from an external baud tick generator that it enables.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int STOP_BITS = DEFAULT_STOP_BITS
) (
    input  logic                           FPGA_CLK1_50,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           baud_en,
    input  logic                           baud_tick,
    output logic                           txd,
    output logic                           busy,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DATA_BITS + 1);

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]     stop_cnt_q, stop_cnt_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_id_q, grant_id_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .en    (state_q == IDLE),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
        end
    end

    // Ticks only matter outside IDLE, where baud_en is always high.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        unique case (state_q)
            IDLE: begin
                if (|arb_grant) begin
                    state_d    = START;
                    shift_d    = req_data[int'(arb_idx) * DATA_BITS +: DATA_BITS];
                    grant_id_d = arb_idx;
                    rr_ptr_d   = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        state_d    = STOP;
                        stop_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == CNT_W'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Dropping baud_en in IDLE re-phases the tick generator for the next frame.
    always_comb begin
        txd       = 1'b1;
        baud_en   = 1'b0;
        busy      = 1'b0;
        req_ready = '0;
        unique case (state_q)
            IDLE:  req_ready = arb_grant;
            START: begin
                txd     = 1'b0;
                baud_en = 1'b1;
                busy    = 1'b1;
            end
            DATA: begin
                txd     = shift_q[0];
                baud_en = 1'b1;
                busy    = 1'b1;
            end
            STOP: begin
                baud_en = 1'b1;
                busy    = 1'b1;
            end
            default: ;
        endcase
    end

    assign grant_id = grant_id_q;

endmodule
